regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Shares the register set's single write port between several writeback sources (ALU result, memory load, I/O input) of the 8-bit core. Uses round-robin arbitration with a valid/ready handshake per requester. Registers the winning write one cycle before it reaches the register set's `wr_en`/`wr_sel`/`reg_in` inputs. A `hold` input lets the control unit freeze all writeback, for example during a stall.

## Interface
Parameters:
- `DataWidth`, 8: register data width.
- `SEL_WIDTH`, 2: register select width.
- `NUM_REQ`, 3: number of requesters, 2..8.

Ports:
- `clk` in 1: the single clock, all state on rising edge.
- `res_n` in 1: reset, asynchronous, active-low.
- `hold` in 1: when 1, no grant is issued.
- `req_valid` in NUM_REQ: requester i has a write pending.
- `req_sel` in NUM_REQ*SEL_WIDTH: flat; requester i uses bits [i*SEL_WIDTH +: SEL_WIDTH].
- `req_data` in NUM_REQ*DataWidth: flat; requester i uses bits [i*DataWidth +: DataWidth].
- `req_ready` out NUM_REQ: one-hot grant; transfer of i when `req_valid[i] & req_ready[i]`.
- `wr_en` out 1: write strobe to the register set.
- `wr_sel` out SEL_WIDTH: target register.
- `reg_in` out DataWidth: write data.
- `grant_id` out 3: index of the last accepted requester, for debug and forwarding.

## Operation
- State:
  - `rr_ptr`, range 0..NUM_REQ-1: highest-priority requester.
  - Output register: `wr_en`, `wr_sel`, `reg_in`, `grant_id`.
- Arbitration (combinational, from current state and inputs):
  - Scan i = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - The first i with `req_valid[i]=1` wins, and `req_ready[i]=1`.
  - `req_ready` is all zero if `hold=1`, no requester is valid, or `res_n=0`.
  - `req_ready[i]` never asserts without `req_valid[i]`.
- On a clock edge with a transfer of winner w:
  - `wr_en`←1, `wr_sel`←req_sel[w], `reg_in`←req_data[w], `grant_id`←w.
  - `rr_ptr`←(w+1) mod NUM_REQ. Wrap: w=NUM_REQ-1 gives rr_ptr=0.
- On a clock edge without a transfer:
  - `wr_en`←0.
  - `wr_sel`, `reg_in`, `grant_id` and `rr_ptr` keep their values.
- Requester rules:
  - A requester keeps `req_valid`, `req_sel` and `req_data` stable until accepted.
  - It may drop `req_valid` only after the accepting edge.
  - Back-to-back requests from the same source are allowed. The source competes again in the next cycle, now with lowest priority.
- No coalescing or ordering between requesters. Two sources writing the same register produce two writes, in grant order.
- Reset (`res_n`=0, asynchronous):
  - `wr_en`=0, `wr_sel`=0, `reg_in`=0, `grant_id`=0, `rr_ptr`=0, `req_ready`=0.
  - A write in flight in the output register is discarded.
  - Requests held across reset are accepted normally after release, starting from requester 0.
- `hold` takes effect in the same cycle (combinational gating of `req_ready`). A write already registered still reaches the register set.

## Timing
- Latency: transfer at edge N → `wr_en=1` during cycle N+1 → the register set captures at edge N+1.
  - The value is readable through the register set read ports from cycle N+2.
- Throughput: one write per cycle, sustained.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of raising `req_valid`, given `hold=0`.
- `req_ready` depends combinationally on `req_valid`, `hold` and `rr_ptr`. It has no combinational path from `req_sel` or `req_data`.

## Structure
- Shared package `jac_regfile_pkg`:
  - DataWidth and SEL_WIDTH defaults, NUM_REGISTERS=4.
  - Requester index constants REQ_ALU=0, REQ_MEM=1, REQ_IO=2.
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ; inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and encoded `gnt_idx`.
  - Purely combinational, reusable for a later bus arbiter.
- Top level holds `rr_ptr`, the output register and the flat-vector slicing mux.

## Test plan
1. Reset then idle: `res_n` low mid-stream with wr_en=1 → all outputs 0 immediately. After release with no valids, wr_en stays 0 for 10 cycles.
2. Single request: req_valid=3'b001, sel=2, data=8'hA5 → req_ready=001 the same cycle. Next cycle wr_en=1, wr_sel=2, reg_in=A5, grant_id=0. The cycle after, wr_en=0.
3. Round-robin fairness: all three valid continuously, data 11/22/33 → grant order 0,1,2,0,1,2. wr_en held at 1 every cycle, and rr_ptr wraps 2→0.
4. Pointer respect: rr_ptr=1 (after a grant to 0), valids=101 → requester 2 wins, then 0.
5. Hold: all valid with hold=1 for 3 cycles → req_ready=000, and wr_en falls to 0 one cycle after hold rises. Release → grants resume at the saved rr_ptr.
6. Same-register conflict: req0 (sel=1, 8'h10) and req1 (sel=1, 8'h20) valid together from rr_ptr=0 → two consecutive writes to register 1, final value 8'h20.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-set write path: default widths, register
// count, requester indices and the round-robin pointer advance helper.
package jac_regfile_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SEL_WIDTH  = 2;
  localparam int NUM_REGISTERS  = 4;
  localparam int REQ_IDX_W      = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_IO  = 2;

  // Pointer following a grant to idx, wrapping after the last requester.
  function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] idx,
                                                   input int unsigned num_req);
    rr_next = (32'(idx) == (num_req - 32'd1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side valid/ready write bus: flat per-requester select and data
// vectors, one-hot ready returned by the arbiter.
interface regfile_wr_arbiter_if
  import jac_regfile_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int SEL_WIDTH = DEF_SEL_WIDTH,
  parameter int DataWidth = DEF_DATA_WIDTH
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*SEL_WIDTH-1:0] req_sel;
  logic [NUM_REQ*DataWidth-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;

  modport master (
    output req_valid,
    output req_sel,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_sel,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr
// (modulo NUM_REQ) wins. Reusable for any request vector of 2..8 bits.
module rr_arbiter
  import jac_regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  input  logic                 en,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [REQ_IDX_W-1:0] gnt_idx
);

  logic [NUM_REQ-1:0]   req_rot_s;
  logic [REQ_IDX_W-1:0] pos_s;
  logic [REQ_IDX_W:0]   sum_s;
  logic                 any_s;

  // Rotating right by ptr puts the highest-priority requester at bit 0.
  assign req_rot_s = NUM_REQ'({req, req} >> ptr);
  assign any_s     = |req_rot_s;

  // Lowest set bit of the rotated vector is the distance from ptr to the winner.
  always_comb begin
    pos_s = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos_s = req_rot_s[k] ? 3'(k) : pos_s;
    end
  end

  assign sum_s   = {1'b0, ptr} + {1'b0, pos_s};
  assign gnt_idx = (sum_s >= 4'(NUM_REQ)) ? 3'(sum_s - 4'(NUM_REQ)) : sum_s[REQ_IDX_W-1:0];

  // Decode the winner index back to a one-hot grant, gated by enable.
  always_comb begin
    gnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt[k] = en & any_s & (gnt_idx == 3'(k));
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register set's single write port between several writeback
// sources with round-robin arbitration and a registered write stage.
module regfile_wr_arbiter
  import jac_regfile_pkg::*;
#(
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int SEL_WIDTH = DEF_SEL_WIDTH,
  parameter int NUM_REQ   = 3
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 hold,
  regfile_wr_arbiter_if.slave  req,
  output logic                 wr_en,
  output logic [SEL_WIDTH-1:0] wr_sel,
  output logic [DataWidth-1:0] reg_in,
  output logic [REQ_IDX_W-1:0] grant_id
);

  logic [REQ_IDX_W-1:0] rr_ptr_r;
  logic                 wr_en_r;
  logic [SEL_WIDTH-1:0] wr_sel_r;
  logic [DataWidth-1:0] reg_in_r;
  logic [REQ_IDX_W-1:0] grant_id_r;

  logic                 arb_en_s;
  logic [NUM_REQ-1:0]   gnt_s;
  logic [REQ_IDX_W-1:0] gnt_idx_s;
  logic                 transfer_s;
  logic [SEL_WIDTH-1:0] sel_mux_s;
  logic [DataWidth-1:0] data_mux_s;

  // Reset is folded in so ready is low while res_n is asserted.
  assign arb_en_s = ~hold & res_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req.req_valid),
    .ptr     (rr_ptr_r),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign req.req_ready = gnt_s;
  assign transfer_s    = |(req.req_valid & gnt_s);

  // Select and data slices of the winning requester; only consumed on a transfer.
  always_comb begin
    sel_mux_s  = '0;
    data_mux_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_mux_s  = (gnt_idx_s == 3'(k)) ? req.req_sel[k*SEL_WIDTH +: SEL_WIDTH] : sel_mux_s;
      data_mux_s = (gnt_idx_s == 3'(k)) ? req.req_data[k*DataWidth +: DataWidth] : data_mux_s;
    end
  end

  // Pointer and write stage; without a transfer only the strobe drops.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rr_ptr_r   <= 3'd0;
      wr_en_r    <= 1'b0;
      wr_sel_r   <= '0;
      reg_in_r   <= '0;
      grant_id_r <= 3'd0;
    end else if (transfer_s) begin
      rr_ptr_r   <= rr_next(gnt_idx_s, NUM_REQ);
      wr_en_r    <= 1'b1;
      wr_sel_r   <= sel_mux_s;
      reg_in_r   <= data_mux_s;
      grant_id_r <= gnt_idx_s;
    end else begin
      wr_en_r    <= 1'b0;
    end
  end

  assign wr_en    = wr_en_r;
  assign wr_sel   = wr_sel_r;
  assign reg_in   = reg_in_r;
  assign grant_id = grant_id_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a behavioural model checked every
// cycle plus hand-computed expectations for each scenario.
module tb_regfile_wr_arbiter;
  import jac_regfile_pkg::*;

  localparam int NR = 3;
  localparam int SW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          res_n;
  logic          hold;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic [DW-1:0] reg_in;
  logic [2:0]    grant_id;

  regfile_wr_arbiter_if #(.NUM_REQ(NR), .SEL_WIDTH(SW), .DataWidth(DW)) rif ();

  regfile_wr_arbiter #(.DataWidth(DW), .SEL_WIDTH(SW), .NUM_REQ(NR)) dut (
    .clk      (clk),
    .res_n    (res_n),
    .hold     (hold),
    .req      (rif.slave),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .reg_in   (reg_in),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: scan from the pointer, first valid wins unless held or in reset.
  function automatic int winner(input logic [NR-1:0] v, input logic h, input logic rn, input int ptr);
    if (h || !rn) return -1;
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] ready_of(input int w);
    logic [NR-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  int            m_ptr;
  logic          m_wr_en;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_data;
  int            m_gid;
  int            w_now;

  assign w_now = winner(rif.req_valid, hold, res_n, m_ptr);

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      m_ptr   <= 0;
      m_wr_en <= 1'b0;
      m_sel   <= '0;
      m_data  <= '0;
      m_gid   <= 0;
    end else if (w_now >= 0) begin
      m_ptr   <= (w_now + 1) % NR;
      m_wr_en <= 1'b1;
      m_sel   <= rif.req_sel[w_now*SW +: SW];
      m_data  <= rif.req_data[w_now*DW +: DW];
      m_gid   <= w_now;
    end else begin
      m_wr_en <= 1'b0;
    end
  end

  // Register set driven by the DUT write port.
  logic [DW-1:0] dut_regs [NUM_REGISTERS];
  always @(posedge clk) begin
    if (wr_en) dut_regs[wr_sel] <= reg_in;
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc ready",    rif.req_ready, ready_of(w_now));
      check("cyc wr_en",    wr_en,         m_wr_en);
      check("cyc wr_sel",   wr_sel,        m_sel);
      check("cyc reg_in",   reg_in,        m_data);
      check("cyc grant_id", grant_id,      m_gid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [SW-1:0] s, input logic [DW-1:0] d);
    rif.req_sel[i*SW +: SW]  = s;
    rif.req_data[i*DW +: DW] = d;
  endtask

  logic [DW-1:0] t3_d [3];

  initial begin
    t3_d[0] = 8'h11; t3_d[1] = 8'h22; t3_d[2] = 8'h33;
    for (int r = 0; r < NUM_REGISTERS; r++) dut_regs[r] = 8'h00;
    res_n = 1'b0;
    hold  = 1'b0;
    rif.req_valid = 3'b000;
    rif.req_sel   = '0;
    rif.req_data  = '0;
    tick(); tick();
    chk_on = 1'b1;
    check("reset wr_en", wr_en, 1'b0);
    check("reset ready", rif.req_ready, 3'b000);
    res_n = 1'b1;
    repeat (10) tick();
    check("idle wr_en", wr_en, 1'b0);

    // single request from requester 0
    set_req(0, 2'd2, 8'hA5);
    rif.req_valid = 3'b001;
    #1 check("single ready", rif.req_ready, 3'b001);
    tick();
    rif.req_valid = 3'b000;
    check("single wr_en", wr_en, 1'b1);
    check("single wr_sel", wr_sel, 2'd2);
    check("single reg_in", reg_in, 8'hA5);
    check("single gid", grant_id, 3'd0);
    tick();
    check("single wr_en off", wr_en, 1'b0);

    // pointer at 1: requester 2 beats requester 0
    set_req(0, 2'd0, 8'h44);
    set_req(2, 2'd3, 8'h66);
    rif.req_valid = 3'b101;
    #1 check("ptr ready", rif.req_ready, 3'b100);
    tick();
    check("ptr gid2", grant_id, 3'd2);
    check("ptr data2", reg_in, 8'h66);
    check("ptr sel2", wr_sel, 2'd3);
    rif.req_valid = 3'b001;
    #1 check("ptr ready0", rif.req_ready, 3'b001);
    tick();
    rif.req_valid = 3'b000;
    check("ptr gid0", grant_id, 3'd0);
    check("ptr data0", reg_in, 8'h44);

    // pointer at 1: a grant to 2 wraps it back to 0
    set_req(2, 2'd3, 8'h77);
    rif.req_valid = 3'b100;
    tick();
    rif.req_valid = 3'b000;
    check("wrap gid", grant_id, 3'd2);

    // round robin across all three, sustained
    set_req(0, 2'd0, 8'h11);
    set_req(1, 2'd1, 8'h22);
    set_req(2, 2'd2, 8'h33);
    rif.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr gid", grant_id, 32'(k % 3));
      check("rr wr_en", wr_en, 1'b1);
      check("rr data", reg_in, t3_d[k % 3]);
    end

    // hold: ready drops now, registered write still lands
    hold = 1'b1;
    #1 check("hold ready", rif.req_ready, 3'b000);
    check("hold wr_en still", wr_en, 1'b1);
    tick();
    check("hold wr_en off", wr_en, 1'b0);
    tick(); tick();
    check("hold wr_en off2", wr_en, 1'b0);
    hold = 1'b0;
    #1 check("hold release ready", rif.req_ready, 3'b001);
    tick();
    check("hold resume gid", grant_id, 3'd0);
    check("hold resume wr_en", wr_en, 1'b1);
    rif.req_valid = 3'b000;

    // pointer 1 -> 0 via requester 2
    rif.req_valid = 3'b100;
    tick();
    rif.req_valid = 3'b000;

    // two writes to register 1, grant order decides the final value
    set_req(0, 2'd1, 8'h10);
    set_req(1, 2'd1, 8'h20);
    rif.req_valid = 3'b011;
    tick();
    rif.req_valid = 3'b010;
    check("conflict first", reg_in, 8'h10);
    check("conflict gid0", grant_id, 3'd0);
    tick();
    rif.req_valid = 3'b000;
    check("conflict second", reg_in, 8'h20);
    check("conflict gid1", grant_id, 3'd1);
    tick();
    check("conflict reg1", dut_regs[1], 8'h20);

    // reset with a write in flight
    rif.req_valid = 3'b111;
    tick();
    check("pre-reset wr_en", wr_en, 1'b1);
    #2 res_n = 1'b0;
    #1;
    check("async wr_en", wr_en, 1'b0);
    check("async wr_sel", wr_sel, 2'd0);
    check("async reg_in", reg_in, 8'h00);
    check("async gid", grant_id, 3'd0);
    check("async ready", rif.req_ready, 3'b000);
    tick();
    res_n = 1'b1;
    #1 check("post-reset ready", rif.req_ready, 3'b001);
    tick();
    check("post-reset gid", grant_id, 3'd0);
    check("post-reset wr_en", wr_en, 1'b1);
    rif.req_valid = 3'b000;
    repeat (10) tick();
    check("final idle wr_en", wr_en, 1'b0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
